// File: rtl/dual_toggle_pkg.sv
// Shared types and defaults for the dual_toggle_gen stimulus generator.
package dual_toggle_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_BURST_W = 16;

endpackage

// File: rtl/dual_toggle_gen_toggle_chan.sv
// One square-wave channel: latches its half-period on load, then toggles
// `out` every `half` cycles while run is high. clr forces the output low
// and takes priority over run so completion/abort edges leave out=0.
module toggle_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             out,
  output logic             tog
);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_eff;

  // A zero half-period would never toggle; treat it as one cycle.
  assign half_eff = (half == '0) ? CNT_W'(1) : half;

  // Toggle strobe must not depend on clr: the top derives clr from it.
  assign tog = run && (cnt == '0);

  // Half-period latch, down-counter and output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      h   <= '0;
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      h   <= half_eff;
      cnt <= half_eff - CNT_W'(1);
      out <= 1'b0;
    end else if (clr) begin
      out <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        out <= ~out;
        cnt <= h - CNT_W'(1);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dual_toggle_gen.sv
// Two-channel programmable square-wave generator feeding fsm.in0/in1.
// Optional coincidence output enabled by defining DUAL_TOGGLE_COINC_EN.
module dual_toggle_gen
  import dual_toggle_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   half0,
  input  logic [CNT_W-1:0]   half1,
  input  logic [BURST_W-1:0] edges,
  output logic               out0,
  output logic               out1,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] edge_cnt
`ifdef DUAL_TOGGLE_COINC_EN
  ,
  output logic               coinc
`endif
);

  state_t             state;
  logic [BURST_W-1:0] limit;
  logic [BURST_W-1:0] nxt_cnt;
  logic               in_run;
  logic               load;
  logic               abort;
  logic               fin;
  logic               clr;
  logic               tog0;
  logic               tog1;

  assign in_run  = (state == RUN);
  assign load    = (state == IDLE) && start && !stop;
  assign nxt_cnt = edge_cnt + BURST_W'(1);
  assign abort   = in_run && stop;
  // Completion: the out0 toggle about to happen is number `limit`.
  assign fin     = in_run && tog0 && (limit != '0) && (nxt_cnt == limit);
  assign clr     = abort || fin;
  assign busy    = in_run;

  toggle_chan #(.CNT_W(CNT_W)) u_ch0 (
    .clk(clk), .rst(rst), .load(load), .run(in_run), .clr(clr),
    .half(half0), .out(out0), .tog(tog0)
  );

  toggle_chan #(.CNT_W(CNT_W)) u_ch1 (
    .clk(clk), .rst(rst), .load(load), .run(in_run), .clr(clr),
    .half(half1), .out(out1), .tog(tog1)
  );

  // Run FSM, edge counter and done pulse; stop wins over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      limit    <= '0;
      edge_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state    <= RUN;
            limit    <= edges;
            edge_cnt <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (fin) begin
            state    <= IDLE;
            edge_cnt <= limit;
            done     <= 1'b1;
          end else if (tog0) begin
            edge_cnt <= nxt_cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUAL_TOGGLE_COINC_EN
  // Pulse when both channels toggle on the same edge, except on the
  // completion/abort edge where outputs are forced low instead.
  always_ff @(posedge clk) begin
    if (rst) coinc <= 1'b0;
    else     coinc <= in_run && !clr && tog0 && tog1;
  end
`endif

endmodule

// File: doc/dual_toggle_gen.md
# dual_toggle_gen

Two-channel programmable square-wave stimulus generator. Drives the two single-bit inputs of the `fsm` block (its `in0`/`in1`) from synthesizable logic instead of bench-only delays. Each channel toggles with its own half-period, and a run can be bounded by an edge count. Sits upstream of `fsm` in self-checking hardware loops and FPGA smoke builds.

## Interface
Parameters:
- `CNT_W`, 16: width of half-period inputs and channel counters.
- `BURST_W`, 16: width of the edge-count limit and the edge counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: run request, sampled only in IDLE.
- `stop` in 1: abort request, sampled in RUN.
- `half0` in CNT_W: channel-0 half-period in cycles; latched at start.
- `half1` in CNT_W: channel-1 half-period in cycles; latched at start.
- `edges` in BURST_W: number of `out0` toggles per run; latched at start; 0 = unbounded.
- `out0` out 1: channel-0 square wave (drives `fsm.in0`).
- `out1` out 1: channel-1 square wave (drives `fsm.in1`).
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on natural completion.
- `edge_cnt` out BURST_W: `out0` toggles so far in the current run.
- `coinc` out 1: present only with `DUAL_TOGGLE_COINC_EN`.

## Operation
- States: IDLE, RUN.
- IDLE to RUN: `start`=1 and `stop`=0.
  - Latch `half0`/`half1`/`edges`; a latched half-period of 0 is treated as 1.
  - Load `cnt0`=h0-1, `cnt1`=h1-1; clear `edge_cnt`; outputs stay 0.
- RUN, per channel, each cycle:
  - cnt==0: toggle out, reload h-1.
  - Otherwise: decrement cnt.
  - `out0` toggle increments `edge_cnt`, wrapping modulo 2^BURST_W.
- Natural completion:
  - Occurs when limit≠0 and the `out0` toggle about to occur is toggle number `edges`.
  - That edge: go to IDLE, `out0`=`out1`=0, `busy`=0, `done`=1 for one cycle, `edge_cnt`=`edges`.
- Abort:
  - `stop`=1 in RUN: next edge goes to IDLE, outputs 0, no `done`, `edge_cnt` holds.
  - `stop` wins over a same-cycle completion, so no `done`.
- `start` in RUN is ignored. `stop` in IDLE is ignored.
- `start`+`stop` together in IDLE: stays IDLE.
- Unbounded run (`edges`=0): `edge_cnt` wraps; only `stop` or `rst` ends it.
- Reset: all outputs 0, state IDLE, counters 0, including mid-run.

## Timing
- `start` sampled at edge k: `busy`=1 after edge k.
- First `out0` toggle after edge k+h0, then every h0 cycles, giving period 2·h0. Same for `out1` with h1.
- Completion at edge k+edges·h0: `busy` falls and `done` pulses at that edge.
- Earliest restart: `start` sampled at the edge after `done`. Min IDLE gap is one cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `DUAL_TOGGLE_COINC_EN` defined:
  - Adds output `coinc`, a registered one-cycle pulse whenever `out0` and `out1` toggle on the same edge.
  - Not asserted on the completion or abort edge. Reset value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `dual_toggle_pkg`:
  - State enum typedef (IDLE, RUN).
  - Default `CNT_W`/`BURST_W` localparams.
- Sub-module `toggle_chan` (param `CNT_W`), instantiated twice:
  - Inputs: `clk`, `rst`, `load`, `run`, `clr`, `half`.
  - Outputs: `out`, `tog` (toggle-this-cycle strobe).
- Top owns the FSM, edge counter, completion/abort logic and the optional coincidence flag.

## Test plan
- Reset mid-run: `rst` held 1 for one edge → `out0`/`out1`/`busy`/`done`/`edge_cnt` all 0 next cycle; no spurious `done`.
- `half0`=13, `half1`=17, `edges`=0, start at edge k:
  - `out0` toggles at k+13, k+26, …; `out1` at k+17, k+34, ….
  - With `DUAL_TOGGLE_COINC_EN`, first `coinc` at k+221.
- `half0`=3, `edges`=4:
  - Toggles at k+3, k+6, k+9.
  - `done` pulse and `busy` fall at k+12; `edge_cnt`=4; outputs 0.
- `half0`=0, `edges`=2 → treated as 1: toggle at k+1, done at k+2.
- `stop` asserted the same cycle as the final toggle (`half0`=2, `edges`=3, stop sampled at k+6) → IDLE, no `done`, `edge_cnt`=2.
- Re-`start` while busy with different `half0` → ignored, period unchanged. `start`+`stop` in IDLE → `busy` stays 0.
